instr_sequencer: RTL
====================

# instr_sequencer

Multi-cycle instruction sequencer for the CPU core: owns the architectural state register and walks each instruction through FETCH/DECODE/EXEC/MEM/WB. Per-cycle enables go to the PC, IR, ALU, data memory, register file and return-address stack. The purely combinational ControlUnit keeps generating the datapath mux selects and ALUop from `state`; this block decides when each stage fires and stalls on memory.

## Interface
- No parameters; widths fixed by the ISA.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: leave IDLE/HALT and begin fetching.
- `inst_type` in 2: 0 R, 1 I, 2 J, 3 reserved (from IR).
- `inst_function` in 5: function field (from IR).
- `stop_bit` in 1: instruction ends a subroutine (return via stack).
- `zero_flag` in 1: ALU zero from EXEC.
- `mem_ready` in 1: memory completes current request this cycle.
- `stack_full`, `stack_empty` in 1 each: return-stack status.
- `state` out 3: current state, feeds ControlUnit.
- `ir_write`, `pc_write` out 1 each: IR / PC load strobes.
- `pc_sel` out 2: 0 PC+1, 1 branch target, 2 jump target, 3 stack top.
- `alu_en`, `rf_we` out 1 each.
- `mem_req`, `mem_we` out 1 each.
- `st_push`, `st_pop` out 1 each.
- `busy` out 1: not IDLE/HALT.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `err` out 1: sticky illegal-type / stack-fault flag.

## Operation
- States (package enum): IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; 7 illegal → HALT with err=1.
- IDLE/HALT: all strobes 0; `start`=1 → FETCH. `err` cleared only by reset.
- FETCH: `mem_req`=1; stays while `mem_ready`=0; on `mem_ready`=1 `ir_write`=1, → DECODE.
- DECODE (1 cycle), by type/function:
  - R, I-ALU (ADDI/ANDI), LW, SW, BEQ → EXEC.
  - J JMP: `pc_write`=1, `pc_sel`=2, `retire`=1 → FETCH.
  - J CALL: if `stack_full`, → HALT, err=1. Else `st_push`=1, `pc_write`=1, `pc_sel`=2, `retire`=1 → FETCH.
  - Type 3: → HALT, err=1, no strobes.
- EXEC (1 cycle, `alu_en`=1): R/I-ALU → WB; LW/SW → MEM; BEQ retires here.
- MEM: `mem_req`=1, `mem_we`=1 for SW; waits on `mem_ready`. LW → WB; SW retires here.
- WB (1 cycle): `rf_we`=1, retires here.
- Retirement (non-J): `pc_write`=1, `retire`=1, → FETCH.
  - `pc_sel`=1 if BEQ and `zero_flag`, else 0.
  - `stop_bit`=1 overrides: if `stack_empty`, → HALT with no `pc_write` (normal program end). Else `st_pop`=1, `pc_sel`=3.
  - `stop_bit` ignored on J-type.
- `st_push` and `st_pop` never assert in the same cycle.

## Timing
- Reset: state=IDLE, every output 0, including `err`. Reset mid-instruction aborts with no further strobes.
- Strobes are Mealy on `mem_ready`, `zero_flag`, `stop_bit`, `stack_*`; otherwise decoded from state.
- Zero-wait memory: `mem_req` and `mem_ready` both high in the same cycle → state advances next edge.
- `inst_*`/`stop_bit` must be stable from DECODE until retirement.
- Minimum latency, fetch to retire: JMP 2 cycles, BEQ 3, SW 4, R 4, LW 5. Each memory wait cycle adds one.

## Configuration
- `SEQ_PERF_CNT_EN` defined: adds outputs `cycle_cnt` [31:0] (increments every `busy` cycle) and `instr_cnt` [31:0] (increments on `retire`). Both reset to 0 and wrap modulo 2^32.
- Undefined: ports and logic absent; core behaviour identical.

## Structure
- Shared package `cpu_ctrl_pkg`: state enum, inst_type codes, function codes (ADDI=0, ANDI=1, LW=2, SW=3, BEQ=4; J: JMP=0, CALL=1), `pc_sel` encoding.
- Sub-module `seq_perf_counters`, instantiated only under `SEQ_PERF_CNT_EN`.

## Test plan
- R-type ADD, `mem_ready` tied 1: states 1→2→3→5→1, `rf_we` in WB, `retire` on cycle 4, `pc_sel`=0.
- LW with 2 wait cycles in MEM: `mem_req` high 3 cycles, `rf_we` in WB, fetch-to-retire 7 cycles.
- BEQ, zero_flag=1 then 0: `pc_sel`=1 then 0, each retiring in EXEC.
- CALL then stop_bit R-type with stack_empty=0: `st_push` in DECODE, later `st_pop` with `pc_sel`=3. Repeat with stack_empty=1: → HALT, no `pc_write`, err=0.
- inst_type=3, and CALL with stack_full=1: HALT, err=1. `start` restarts at FETCH and err stays 1 until reset.
- Reset asserted mid-MEM: outputs 0 asynchronously, state=IDLE; with `SEQ_PERF_CNT_EN`, counters read 0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Brief    : Shared CPU control encodings: sequencer states, instruction
//            types and function codes, PC source select.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    localparam logic [1:0] C_TYPE_R   = 2'd0;
    localparam logic [1:0] C_TYPE_I   = 2'd1;
    localparam logic [1:0] C_TYPE_J   = 2'd2;
    localparam logic [1:0] C_TYPE_RSV = 2'd3;

    localparam logic [4:0] C_FN_ADDI = 5'd0;
    localparam logic [4:0] C_FN_ANDI = 5'd1;
    localparam logic [4:0] C_FN_LW   = 5'd2;
    localparam logic [4:0] C_FN_SW   = 5'd3;
    localparam logic [4:0] C_FN_BEQ  = 5'd4;
    localparam logic [4:0] C_FN_JMP  = 5'd0;
    localparam logic [4:0] C_FN_CALL = 5'd1;

    localparam logic [1:0] C_PC_INC    = 2'd0;
    localparam logic [1:0] C_PC_BRANCH = 2'd1;
    localparam logic [1:0] C_PC_JUMP   = 2'd2;
    localparam logic [1:0] C_PC_STACK  = 2'd3;

    typedef enum logic [1:0] {
        CLS_ALU    = 2'd0,
        CLS_LOAD   = 2'd1,
        CLS_STORE  = 2'd2,
        CLS_BRANCH = 2'd3
    } iclass_e;

    // Path class of a non-J instruction; unlisted I functions run as ALU ops.
    function automatic iclass_e classify(input logic [1:0] itype, input logic [4:0] fn);
        iclass_e cls;
        cls = CLS_ALU;
        if (itype == C_TYPE_I) begin
            case (fn)
                C_FN_ADDI, C_FN_ANDI: cls = CLS_ALU;
                C_FN_LW:              cls = CLS_LOAD;
                C_FN_SW:              cls = CLS_STORE;
                C_FN_BEQ:             cls = CLS_BRANCH;
                default:              cls = CLS_ALU;
            endcase
        end
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer_if
// Brief    : Sequencer <-> datapath bundle: IR/status inputs, stage strobes.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if;

    logic       start;
    logic [1:0] inst_type;
    logic [4:0] inst_function;
    logic       stop_bit;
    logic       zero_flag;
    logic       mem_ready;
    logic       stack_full;
    logic       stack_empty;

    logic [2:0] state;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       alu_en;
    logic       rf_we;
    logic       mem_req;
    logic       mem_we;
    logic       st_push;
    logic       st_pop;
    logic       busy;
    logic       retire;
    logic       err;

    modport master (
        input  start, inst_type, inst_function, stop_bit, zero_flag,
               mem_ready, stack_full, stack_empty,
        output state, ir_write, pc_write, pc_sel, alu_en, rf_we, mem_req,
               mem_we, st_push, st_pop, busy, retire, err
    );

    modport slave (
        output start, inst_type, inst_function, stop_bit, zero_flag,
               mem_ready, stack_full, stack_empty,
        input  state, ir_write, pc_write, pc_sel, alu_en, rf_we, mem_req,
               mem_we, st_push, st_pop, busy, retire, err
    );

endinterface
`default_nettype wire

// File: rtl/seq_perf_counters.sv
`default_nettype none
// ============================================================================
// Module   : seq_perf_counters
// Brief    : Busy-cycle and retired-instruction counters, wrap at 2^32.
//            Only instantiated when SEQ_PERF_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module seq_perf_counters (
    input  logic        clk,
    input  logic        reset,
    input  logic        busy,
    input  logic        retire,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
);

    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + {31'd0, busy};
        instr_cnt_d = instr_cnt_q + {31'd0, retire};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_q <= 32'd0;
            instr_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with Mealy stage
//            strobes. SEQ_PERF_CNT_EN adds cycle_cnt / instr_cnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
`ifdef SEQ_PERF_CNT_EN
    output logic [31:0]          cycle_cnt,
    output logic [31:0]          instr_cnt,
`endif
    instr_sequencer_if.master    bus
);

    state_e     state_q, state_d;
    logic       err_q, err_d;
    iclass_e    w_iclass;
    logic       w_call;
    logic       w_retire_req;
    logic       w_ir_write, w_pc_write, w_alu_en, w_rf_we;
    logic       w_mem_req, w_mem_we, w_st_push, w_st_pop, w_retire;
    logic [1:0] w_pc_sel;

    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        w_iclass     = classify(bus.inst_type, bus.inst_function);
        w_call       = 1'b0;
        w_retire_req = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_sel     = C_PC_INC;
        w_alu_en     = 1'b0;
        w_rf_we      = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_st_push    = 1'b0;
        w_st_pop     = 1'b0;
        w_retire     = 1'b0;

        case (bus.inst_function)
            C_FN_JMP:  w_call = 1'b0;
            C_FN_CALL: w_call = 1'b1;
            default:   w_call = 1'b0;
        endcase

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (bus.start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                w_mem_req = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_write = 1'b1;
                    state_d    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (bus.inst_type)
                    C_TYPE_R, C_TYPE_I: state_d = ST_EXEC;
                    C_TYPE_J: begin
                        if (w_call && bus.stack_full) begin
                            state_d = ST_HALT;
                            err_d   = 1'b1;
                        end else begin
                            w_st_push  = w_call;
                            w_pc_write = 1'b1;
                            w_pc_sel   = C_PC_JUMP;
                            w_retire   = 1'b1;
                            state_d    = ST_FETCH;
                        end
                    end
                    C_TYPE_RSV: begin
                        state_d = ST_HALT;
                        err_d   = 1'b1;
                    end
                    default: state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                w_alu_en = 1'b1;
                case (w_iclass)
                    CLS_LOAD, CLS_STORE: state_d      = ST_MEM;
                    CLS_BRANCH:          w_retire_req = 1'b1;
                    default:             state_d      = ST_WB;
                endcase
            end
            ST_MEM: begin
                w_mem_req = 1'b1;
                w_mem_we  = (w_iclass == CLS_STORE);
                if (bus.mem_ready) begin
                    if (w_iclass == CLS_STORE) w_retire_req = 1'b1;
                    else                       state_d      = ST_WB;
                end
            end
            ST_WB: begin
                w_rf_we      = 1'b1;
                w_retire_req = 1'b1;
            end
            default: begin
                state_d = ST_HALT;
                err_d   = 1'b1;
            end
        endcase

        // Common retirement for R/I paths; a stop with an empty stack ends the program.
        if (w_retire_req) begin
            w_retire = 1'b1;
            if (bus.stop_bit) begin
                if (bus.stack_empty) begin
                    state_d = ST_HALT;
                end else begin
                    w_st_pop   = 1'b1;
                    w_pc_write = 1'b1;
                    w_pc_sel   = C_PC_STACK;
                    state_d    = ST_FETCH;
                end
            end else begin
                w_pc_write = 1'b1;
                w_pc_sel   = (w_iclass == CLS_BRANCH && bus.zero_flag) ? C_PC_BRANCH : C_PC_INC;
                state_d    = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.ir_write = w_ir_write;
    assign bus.pc_write = w_pc_write;
    assign bus.pc_sel   = w_pc_sel;
    assign bus.alu_en   = w_alu_en;
    assign bus.rf_we    = w_rf_we;
    assign bus.mem_req  = w_mem_req;
    assign bus.mem_we   = w_mem_we;
    assign bus.st_push  = w_st_push;
    assign bus.st_pop   = w_st_pop;
    assign bus.retire   = w_retire;
    assign bus.busy     = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign bus.err      = err_q;

`ifdef SEQ_PERF_CNT_EN
    seq_perf_counters u_perf (
        .clk       (clk),
        .reset     (reset),
        .busy      (bus.busy),
        .retire    (w_retire),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );
`endif

endmodule
`default_nettype wire
